// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline/hazard-controller signal bundle
//
// Purpose: carries the pipeline state the hazard controller observes and the
// stall/flush/forward/multiply controls it returns.
// Parameter: STAT_W - width of the statistics counters.
// Modports:
//   master - pipeline side: drives register ids / enables / instruction flags,
//            receives StallF/StallD/FlushD/FlushE, Forward*, Mul*, *Cnt.
//   slave  - hazard controller side (directions reversed).
interface pipeline_hazard_ctrl_if #(
    parameter int STAT_W = 32
);
    logic [4:0]        RsD, RtD, RsE, RtE;
    logic [4:0]        WriteRegE, WriteRegM, WriteRegW;
    logic              RFWEE, RFWEM, RFWEW;
    logic              MtoRFSelE, MtoRFSelM;
    logic              BranchD, PCSrcD, JumpD;
    logic              MulStartD, MulStartE, MfhiD;

    logic              StallF, StallD, FlushD, FlushE;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              ForwardAD, ForwardBD;
    logic              MulBusy, MulDone, MulOverlap;
    logic [STAT_W-1:0] StallCnt, FlushCnt;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM,
               BranchD, PCSrcD, JumpD, MulStartD, MulStartE, MfhiD,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MulBusy, MulDone, MulOverlap,
               StallCnt, FlushCnt
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM,
               BranchD, PCSrcD, JumpD, MulStartD, MulStartE, MfhiD,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MulBusy, MulDone, MulOverlap,
               StallCnt, FlushCnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage MIPS hazard, forwarding and multiply sequencing
//
// Purpose: generates stall/flush controls for IF/ID and ID/EX, E- and D-stage
// forwarding selects, and tracks the multi-cycle multiplier with an IDLE/BUSY FSM.
// Parameters: MUL_LAT (multiply latency, >= 2), STAT_W (statistics width).
// Ports:
//   CLK - clock, rising edge
//   CLR - asynchronous active-high reset; forces all combinational outputs to 0
//   hz  - pipeline_hazard_ctrl_if.slave bundle (see interface file)
// Optional feature: define HAZARD_STATS_EN to build saturating stall/flush
// counters; otherwise StallCnt/FlushCnt are tied to 0.
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int STAT_W  = 32
) (
    input logic                    CLK,
    input logic                    CLR,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int CNT_W = $clog2(MUL_LAT);

    typedef enum logic {ST_IDLE, ST_BUSY} mul_state_t;

    mul_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             mul_done;
    logic             mul_overlap;

    logic             lwstall, brstall, mulstall, stall;
    logic [1:0]       fwd_ae, fwd_be;
    logic             fwd_ad, fwd_bd, flush_d;

    // Register 0 is hard-wired zero, so a write to it never forwards or stalls.
    always_comb begin
        fwd_ae   = 2'b00;
        fwd_be   = 2'b00;
        fwd_ad   = 1'b0;
        fwd_bd   = 1'b0;
        lwstall  = 1'b0;
        brstall  = 1'b0;
        mulstall = 1'b0;
        stall    = 1'b0;
        flush_d  = 1'b0;
        if (!CLR) begin
            // M stage holds the newer result, so it wins over W.
            if (hz.RFWEM && hz.WriteRegM != 5'd0 && hz.WriteRegM == hz.RsE)
                fwd_ae = 2'b10;
            else if (hz.RFWEW && hz.WriteRegW != 5'd0 && hz.WriteRegW == hz.RsE)
                fwd_ae = 2'b01;

            if (hz.RFWEM && hz.WriteRegM != 5'd0 && hz.WriteRegM == hz.RtE)
                fwd_be = 2'b10;
            else if (hz.RFWEW && hz.WriteRegW != 5'd0 && hz.WriteRegW == hz.RtE)
                fwd_be = 2'b01;

            fwd_ad = hz.RFWEM && hz.WriteRegM != 5'd0 && hz.WriteRegM == hz.RsD;
            fwd_bd = hz.RFWEM && hz.WriteRegM != 5'd0 && hz.WriteRegM == hz.RtD;

            lwstall = hz.MtoRFSelE && hz.RtE != 5'd0 &&
                      (hz.RtE == hz.RsD || hz.RtE == hz.RtD);

            // Branch compares in D, so an ALU result still in E or a load
            // still in M cannot be forwarded in time.
            brstall = hz.BranchD &&
                      ((hz.RFWEE && hz.WriteRegE != 5'd0 &&
                        (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
                       (hz.MtoRFSelM && hz.WriteRegM != 5'd0 &&
                        (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));

            mulstall = (state == ST_BUSY) && (hz.MfhiD || hz.MulStartD);

            stall   = lwstall | brstall | mulstall;
            // A stalled branch/jump is re-evaluated next cycle; don't flush yet.
            flush_d = (hz.PCSrcD | hz.JumpD) & ~stall;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mul_done    <= 1'b0;
            mul_overlap <= 1'b0;
        end else begin
            mul_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hz.MulStartE) begin
                        state <= ST_BUSY;
                        cnt   <= CNT_W'(MUL_LAT - 1);
                    end
                end
                ST_BUSY: begin
                    // A launch while busy is not a restart; only flag it.
                    if (hz.MulStartE)
                        mul_overlap <= 1'b1;
                    if (cnt == '0) begin
                        state    <= ST_IDLE;
                        mul_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != {STAT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if ((flush_d | stall) && flush_cnt != {STAT_W{1'b1}})
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.StallCnt = stall_cnt;
    assign hz.FlushCnt = flush_cnt;
`else
    assign hz.StallCnt = '0;
    assign hz.FlushCnt = '0;
`endif

    assign hz.StallF     = stall;
    assign hz.StallD     = stall;
    assign hz.FlushE     = stall;
    assign hz.FlushD     = flush_d;
    assign hz.ForwardAE  = fwd_ae;
    assign hz.ForwardBE  = fwd_be;
    assign hz.ForwardAD  = fwd_ad;
    assign hz.ForwardBD  = fwd_bd;
    assign hz.MulBusy    = (state == ST_BUSY);
    assign hz.MulDone    = mul_done;
    assign hz.MulOverlap = mul_overlap;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
`ifdef HAZARD_STATS_EN
    localparam int STAT_W = 3;
`else
    localparam int STAT_W = 32;
`endif

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl_if #(.STAT_W(STAT_W)) hz();

    pipeline_hazard_ctrl #(.MUL_LAT(4), .STAT_W(STAT_W)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .hz  (hz)
    );

    typedef struct {
        int          id;
        logic [12:0] v;
        bit          chk;
        int          sc;
        int          fc;
    } exp_t;

    exp_t q[$];
    exp_t mx;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_id  = 0;
    logic [12:0]       act;
    logic [STAT_W-1:0] esc, efc;

    function automatic logic [12:0] mk(input logic s, input logic fd,
                                       input logic [1:0] ae, input logic [1:0] be,
                                       input logic ad, input logic bd,
                                       input logic b, input logic d, input logic o);
        return {s, s, s, fd, ae, be, ad, bd, b, d, o};
    endfunction

    task automatic clr_in();
        hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
        hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
        hz.RFWEE = 0; hz.RFWEM = 0; hz.RFWEW = 0;
        hz.MtoRFSelE = 0; hz.MtoRFSelM = 0;
        hz.BranchD = 0; hz.PCSrcD = 0; hz.JumpD = 0;
        hz.MulStartD = 0; hz.MulStartE = 0; hz.MfhiD = 0;
    endtask

    task automatic step(input logic [12:0] e, input bit chk, input int sc, input int fc);
        exp_t x;
        x.id = vec_id; x.v = e; x.chk = chk; x.sc = sc; x.fc = fc;
        vec_id++;
        q.push_back(x);
        @(posedge CLK);
        #1;
    endtask

    task automatic lw_hazard();
        clr_in();
        hz.MtoRFSelE = 1; hz.RtE = 8; hz.RsD = 8;
    endtask

    // Monitor: outputs are valid every cycle; pop one expectation per cycle.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            mx  = q.pop_front();
            act = {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD, hz.ForwardAE, hz.ForwardBE,
                   hz.ForwardAD, hz.ForwardBD, hz.MulBusy, hz.MulDone, hz.MulOverlap};
            n_tests++;
            if (act !== mx.v) begin
                n_fail++;
                $display("FAIL vec%0d outputs: got %b expected %b", mx.id, act, mx.v);
            end
            if (mx.chk) begin
`ifdef HAZARD_STATS_EN
                esc = STAT_W'(mx.sc);
                efc = STAT_W'(mx.fc);
`else
                esc = '0;
                efc = '0;
`endif
                n_tests++;
                if (hz.StallCnt !== esc) begin
                    n_fail++;
                    $display("FAIL vec%0d StallCnt: got %0d expected %0d", mx.id, hz.StallCnt, esc);
                end
                n_tests++;
                if (hz.FlushCnt !== efc) begin
                    n_fail++;
                    $display("FAIL vec%0d FlushCnt: got %0d expected %0d", mx.id, hz.FlushCnt, efc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        clr_in();
        @(posedge CLK);
        #1;
        // Reset: a matching forward must be masked while CLR is high.
        hz.RFWEM = 1; hz.WriteRegM = 5; hz.RsE = 5; hz.MtoRFSelE = 1; hz.RtE = 3; hz.RsD = 3;
        step(mk(0,0,2'b00,2'b00,0,0,0,0,0), 1, 0, 0);
        CLR = 0;

        // Forwarding
        clr_in(); hz.RFWEM = 1; hz.WriteRegM = 5; hz.RsE = 5; hz.RFWEW = 1; hz.WriteRegW = 5;
        step(mk(0,0,2'b10,2'b00,0,0,0,0,0), 0, 0, 0);
        hz.WriteRegM = 0;
        step(mk(0,0,2'b01,2'b00,0,0,0,0,0), 0, 0, 0);
        clr_in(); hz.RFWEM = 1; hz.RFWEW = 1;
        step(mk(0,0,2'b00,2'b00,0,0,0,0,0), 0, 0, 0);
        clr_in(); hz.RFWEM = 1; hz.WriteRegM = 7; hz.RtE = 7; hz.RsD = 7; hz.RtD = 7;
        hz.RFWEW = 1; hz.WriteRegW = 7; hz.RsE = 9;
        step(mk(0,0,2'b00,2'b10,1,1,0,0,0), 0, 0, 0);
        clr_in(); hz.RFWEW = 1; hz.WriteRegW = 12; hz.RtE = 12; hz.WriteRegM = 12;
        step(mk(0,0,2'b00,2'b01,0,0,0,0,0), 0, 0, 0);

        // Load-use stall
        lw_hazard();
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 0, 0, 0);
        clr_in(); hz.MtoRFSelE = 1;
        step(mk(0,0,2'b00,2'b00,0,0,0,0,0), 0, 0, 0);
        clr_in(); hz.MtoRFSelE = 1; hz.RtE = 8; hz.RtD = 8; hz.RsD = 1;
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 0, 0, 0);

        // Branch stall / flush
        clr_in(); hz.BranchD = 1; hz.RFWEE = 1; hz.WriteRegE = 3; hz.RtD = 3; hz.PCSrcD = 1;
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 0, 0, 0);
        clr_in(); hz.BranchD = 1; hz.PCSrcD = 1;
        step(mk(0,1,2'b00,2'b00,0,0,0,0,0), 0, 0, 0);
        clr_in(); hz.BranchD = 1; hz.MtoRFSelM = 1; hz.WriteRegM = 4; hz.RsD = 4;
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 0, 0, 0);
        clr_in(); hz.BranchD = 1; hz.RFWEE = 1; hz.JumpD = 1;
        step(mk(0,1,2'b00,2'b00,0,0,0,0,0), 0, 0, 0);

        // Multiply: 4 busy cycles, done on the 5th, MfhiD stalls while busy
        clr_in(); hz.MulStartE = 1; hz.MfhiD = 1;
        step(mk(0,0,2'b00,2'b00,0,0,0,0,0), 0, 0, 0);
        hz.MulStartE = 0;
        for (int i = 0; i < 4; i++)
            step(mk(1,0,2'b00,2'b00,0,0,1,0,0), 0, 0, 0);
        // Done pulse and new launch in the same cycle
        hz.MfhiD = 0; hz.MulStartE = 1;
        step(mk(0,0,2'b00,2'b00,0,0,0,1,0), 0, 0, 0);
        hz.MulStartE = 0;
        step(mk(0,0,2'b00,2'b00,0,0,1,0,0), 0, 0, 0);
        hz.MulStartE = 1;
        step(mk(0,0,2'b00,2'b00,0,0,1,0,0), 0, 0, 0);
        hz.MulStartE = 0;
        step(mk(0,0,2'b00,2'b00,0,0,1,0,1), 0, 0, 0);
        step(mk(0,0,2'b00,2'b00,0,0,1,0,1), 0, 0, 0);
        step(mk(0,0,2'b00,2'b00,0,0,0,1,1), 0, 0, 0);
        hz.MulStartE = 1;
        step(mk(0,0,2'b00,2'b00,0,0,0,0,1), 0, 0, 0);
        hz.MulStartE = 0; hz.MulStartD = 1;
        step(mk(1,0,2'b00,2'b00,0,0,1,0,1), 0, 0, 0);
        step(mk(1,0,2'b00,2'b00,0,0,1,0,1), 0, 0, 0);
        // CLR mid-busy: everything drops immediately
        CLR = 1; hz.RFWEM = 1; hz.WriteRegM = 6; hz.RsE = 6;
        step(mk(0,0,2'b00,2'b00,0,0,0,0,0), 1, 0, 0);
        CLR = 0; clr_in();
        step(mk(0,0,2'b00,2'b00,0,0,0,0,0), 1, 0, 0);

        // Statistics: 3 stalls + 1 flush, then saturation at 3'b111
        lw_hazard();
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 1, 0, 0);
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 1, 1, 1);
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 1, 2, 2);
        clr_in(); hz.PCSrcD = 1;
        step(mk(0,1,2'b00,2'b00,0,0,0,0,0), 1, 3, 3);
        clr_in();
        step(mk(0,0,2'b00,2'b00,0,0,0,0,0), 1, 3, 4);
        lw_hazard();
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 1, 3, 4);
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 1, 4, 5);
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 1, 5, 6);
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 1, 6, 7);
        step(mk(1,0,2'b00,2'b00,0,0,0,0,0), 1, 7, 7);
        clr_in();
        step(mk(0,0,2'b00,2'b00,0,0,0,0,0), 1, 7, 7);

        repeat (3) @(posedge CLK);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
